// File: rtl/metro_mpi_pkg.sv
// Types and defaults shared by the MPI sender and receiver stages.
package metro_mpi_pkg;

    typedef logic [63:0] flit_t;

    localparam int DEFAULT_NUM_CREDITS = 7;
    localparam int DEFAULT_FIFO_DEPTH  = 4;

    function automatic int credit_width(input int num_credits);
        return $clog2(num_credits + 1);
    endfunction

endpackage

// File: rtl/sender_mpi_if.sv
// Producer-side handshake and channel-side flit/credit signals of the MPI sender.
interface sender_mpi_if;
    import metro_mpi_pkg::*;

    logic  in_valid;
    flit_t in_data;
    logic  in_ready;
    logic  out_valid;
    flit_t out_data;
    logic  out_yummy;

    // master: the sender itself; slave: producer plus downstream receiver
    modport master (
        input  in_valid, in_data, out_yummy,
        output in_ready, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, out_yummy,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/sender_fifo_mpi.sv
// Staging FIFO for the MPI sender; caller never pushes when full or pops when empty.
module sender_fifo_mpi
    import metro_mpi_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  flit_t                       wdata_i,
    output flit_t                       rdata_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    flit_t         mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wptr_d  = wptr_q + AW'(push_i);
        rptr_d  = rptr_q + AW'(pop_i);
        count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sender_mpi.sv
// Credit-based MPI transmit stage: staging FIFO, credit counter, registered channel output.
// Optional statistics counters are enabled by defining METRO_MPI_SEND_STATS_EN.
module sender_mpi
    import metro_mpi_pkg::*;
#(
    parameter int NUM_CREDITS = DEFAULT_NUM_CREDITS,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic [31:0]                        rank_i,
    sender_mpi_if.master                       bus,
    output logic [$clog2(NUM_CREDITS+1)-1:0]   credit_o,
    output logic                               credit_err_o
`ifdef METRO_MPI_SEND_STATS_EN
    ,
    output logic [31:0]                        sent_cnt_o,
    output logic [31:0]                        stall_cnt_o
`endif
);

    localparam int CW = credit_width(NUM_CREDITS);
    localparam int AW = $clog2(FIFO_DEPTH);

    flit_t         fifo_rdata;
    logic [AW:0]   fifo_count;
    logic          push;
    logic          send;
    logic [CW-1:0] credit_q, credit_d;
    logic          err_q, err_d;
    logic          ovf;
    logic          valid_q;
    flit_t         data_q, data_d;
    logic          rank_unused;

    // Returns {overflow, next credit}; a return at full credit is flagged, never wrapped.
    function automatic logic [CW:0] credit_next(input logic [CW-1:0] cur,
                                                 input logic          snd,
                                                 input logic          yum);
        logic [CW:0] r;
        r = {1'b0, cur};
        if (snd && !yum) begin
            r[CW-1:0] = cur - CW'(1);
        end else if (yum && !snd) begin
            if (cur == CW'(NUM_CREDITS)) begin
                r[CW] = 1'b1;
            end else begin
                r[CW-1:0] = cur + CW'(1);
            end
        end
        return r;
    endfunction

    assign bus.in_ready = (fifo_count != (AW+1)'(FIFO_DEPTH));
    assign push         = bus.in_valid & bus.in_ready;
    assign send         = (fifo_count != '0) && (credit_q != '0);

    sender_fifo_mpi #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push),
        .pop_i   (send),
        .wdata_i (bus.in_data),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    always_comb begin
        {ovf, credit_d} = credit_next(credit_q, send, bus.out_yummy);
        err_d           = err_q | ovf;
        data_d          = send ? fifo_rdata : data_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            credit_q <= CW'(NUM_CREDITS);
            err_q    <= 1'b0;
        end else begin
            valid_q  <= send;
            data_q   <= data_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign credit_o      = credit_q;
    assign credit_err_o  = err_q;

    // The rank only identifies the node in debug messages; no logic depends on it.
    assign rank_unused = ^rank_i;

`ifdef METRO_MPI_SEND_STATS_EN
    logic [31:0] sent_q, sent_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        sent_d  = sent_q + 32'(send);
        stall_d = stall_q + 32'((fifo_count != '0) && (credit_q == '0));
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sent_q  <= '0;
            stall_q <= '0;
        end else begin
            sent_q  <= sent_d;
            stall_q <= stall_d;
        end
    end

    assign sent_cnt_o  = sent_q;
    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_sender_mpi.sv
// Scoreboard bench for sender_mpi: directed flits and credit pulses, monitor checks channel order.
module tb_sender_mpi;
    import metro_mpi_pkg::*;

    localparam int NC = 7;
    localparam int FD = 4;
    localparam int CW = $clog2(NC + 1);

    logic          clk = 1'b0;
    logic          rstn;
    logic [31:0]   rank = 32'd3;
    logic [CW-1:0] credit;
    logic          err;
`ifdef METRO_MPI_SEND_STATS_EN
    logic [31:0]   sent_cnt;
    logic [31:0]   stall_cnt;
`endif

    sender_mpi_if bus();

    sender_mpi #(
        .NUM_CREDITS (NC),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .rank_i       (rank),
        .bus          (bus),
        .credit_o     (credit),
        .credit_err_o (err)
`ifdef METRO_MPI_SEND_STATS_EN
        ,
        .sent_cnt_o   (sent_cnt),
        .stall_cnt_o  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    flit_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every flit on the channel must be the oldest outstanding expected flit.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_flit actual=0x%0h expected=none", bus.out_data);
                end else begin
                    flit_t e;
                    e = sb.pop_front();
                    check("flit_order", bus.out_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_flits(input int n, input logic [63:0] base);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 200) begin
            bus.in_valid = 1'b1;
            bus.in_data  = base + 64'(k);
            if (bus.in_ready === 1'b1) begin
                sb.push_back(base + 64'(k));
                k++;
            end
            tick();
            guard++;
        end
        bus.in_valid = 1'b0;
        if (k < n) check("push_timeout", 64'(k), 64'(n));
    endtask

    task automatic pulse_yummy(input int n);
        bus.out_yummy = 1'b1;
        repeat (n) tick();
        bus.out_yummy = 1'b0;
    endtask

    initial begin
        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_yummy = 1'b0;
        #12;
        check("rst_valid",  64'(bus.out_valid), 64'd0);
        check("rst_data",   bus.out_data,       64'd0);
        check("rst_credit", 64'(credit),        64'd7);
        check("rst_err",    64'(err),           64'd0);
        check("rst_ready",  64'(bus.in_ready),  64'd1);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // single flit: pushed at one edge, on the channel after the next
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hA5A5;
        sb.push_back(64'hA5A5);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("t1_valid",  64'(bus.out_valid), 64'd1);
        check("t1_data",   bus.out_data,       64'hA5A5);
        check("t1_credit", 64'(credit),        64'd6);
        pulse_yummy(1);
        check("t1_credit_back", 64'(credit),        64'd7);
        check("t1_valid_drop",  64'(bus.out_valid), 64'd0);

        // ten flits without credit return: seven leave, three wait
        push_flits(10, 64'h1000);
        check("t2_credit",   64'(credit),       64'd0);
        check("t2_ready_3",  64'(bus.in_ready), 64'd1);
        push_flits(1, 64'h100A);
        check("t2_ready_full", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hDEAD;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        check("t2_ready_hold", 64'(bus.in_ready),  64'd0);
        check("t2_pending",    64'(sb.size()),     64'd4);
        check("t2_idle_valid", 64'(bus.out_valid), 64'd0);

        // three credits returned release three flits
        pulse_yummy(3);
        repeat (3) tick();
        check("t3_pending", 64'(sb.size()),    64'd1);
        check("t3_credit",  64'(credit),       64'd0);
        check("t3_ready",   64'(bus.in_ready), 64'd1);

        // drain, then send and yummy together at credit 4
        pulse_yummy(1);
        repeat (2) tick();
        check("t4_drained", 64'(sb.size()), 64'd0);
        check("t4_credit0", 64'(credit),    64'd0);
        pulse_yummy(4);
        check("t4_credit4", 64'(credit), 64'd4);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hC0DE4;
        sb.push_back(64'hC0DE4);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_yummy = 1'b1;
        tick();
        bus.out_yummy = 1'b0;
        check("t4_credit_same", 64'(credit),        64'd4);
        check("t4_valid",       64'(bus.out_valid), 64'd1);
        check("t4_data",        bus.out_data,       64'hC0DE4);
        pulse_yummy(3);
        check("t4_credit_full", 64'(credit), 64'd7);
        check("t4_err_clear",   64'(err),    64'd0);

        // overflow: yummy at full credit is sticky-flagged
        pulse_yummy(1);
        check("t5_credit", 64'(credit), 64'd7);
        check("t5_err",    64'(err),    64'd1);
        repeat (3) tick();
        check("t5_err_sticky", 64'(err), 64'd1);

        // reset mid-operation: two flits queued, one on the channel
        push_flits(10, 64'h2000);
        pulse_yummy(1);
        tick();
        check("t6_pre_valid", 64'(bus.out_valid), 64'd1);
        check("t6_pre_data",  bus.out_data,       64'h2007);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("t6_valid",  64'(bus.out_valid), 64'd0);
        check("t6_data",   bus.out_data,       64'd0);
        check("t6_credit", 64'(credit),        64'd7);
        check("t6_err",    64'(err),           64'd0);
        check("t6_ready",  64'(bus.in_ready),  64'd1);
`ifdef METRO_MPI_SEND_STATS_EN
        check("t6_sent_cnt",  64'(sent_cnt),  64'd0);
        check("t6_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        check("t6_dropped", 64'(sb.size()), 64'd2);
        sb.delete();
        @(posedge clk);
        #2;
        rstn = 1'b1;
        repeat (4) tick();
        check("t6_post_valid",  64'(bus.out_valid), 64'd0);
        check("t6_post_credit", 64'(credit),        64'd7);
        check("t6_post_ready",  64'(bus.in_ready),  64'd1);
        check("final_pending",  64'(sb.size()),     64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
